// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART byte transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

    // Truncating clocks-per-bit; the residual rate error is tolerated.
    function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte valid/ready handshake between a byte producer and the UART transmitter.
interface uart_byte_tx_if
    import uart_pkg::*;
();
    uart_byte_t data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: tick is high in the last cycle of each CLKS_PER_BIT period.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nx;

    always_comb begin
        count_nx = count + CNT_W'(1);
        if (clear || (count == LAST)) begin
            count_nx = '0;
        end
    end

    // tick is registered by looking at the count value the next cycle will hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= count_nx;
            tick  <= (count_nx == LAST);
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// Fixed-rate 8N1/8N2 UART transmitter fed by a byte valid/ready handshake.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_byte_tx_if.slave        byte_if,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);

    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("uart_byte_tx: CLKS_PER_BIT must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_byte_tx: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_t state;
    uart_tx_state_t state_nx;
    uart_byte_t     shift;
    uart_byte_t     shift_nx;
    logic [2:0]     idx;
    logic [2:0]     idx_nx;
    logic           ready_q;
    logic           tx_nx;
    logic           accept_c;
    logic           timer_clear_c;
    logic           tick;

    assign byte_if.ready = ready_q;
    assign accept_c      = byte_if.valid && ready_q;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear_c),
        .tick (tick)
    );

    // Next state; idx counts data bits in DATA and stop bits in STOP.
    always_comb begin
        state_nx      = state;
        shift_nx      = shift;
        idx_nx        = idx;
        timer_clear_c = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    shift_nx      = byte_if.data;
                    timer_clear_c = 1'b1;
                    state_nx      = START;
                end
            end
            START: begin
                if (tick) begin
                    state_nx = DATA;
                    idx_nx   = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_nx = shift >> 1;
                    if (idx == 3'(UART_DATA_BITS - 1)) begin
                        state_nx = STOP;
                        idx_nx   = 3'd0;
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (idx == 3'(STOP_BITS - 1)) begin
                        state_nx = IDLE;
                        idx_nx   = 3'd0;
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        tx_nx = UART_IDLE_LEVEL;
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift_nx[0];
            default: tx_nx = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            idx     <= 3'd0;
            tx      <= UART_IDLE_LEVEL;
            ready_q <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            shift   <= shift_nx;
            idx     <= idx_nx;
            tx      <= tx_nx;
            ready_q <= (state_nx == IDLE);
            busy    <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Randomized self-checking bench for uart_byte_tx against a frame-level line model.
module tb_uart_byte_tx;

    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    logic rst;
    logic tx1, busy1, tx2, busy2;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    uart_byte_tx_if if1();
    uart_byte_tx_if if2();

    uart_byte_tx #(.CLK_FREQ_HZ(4), .BAUD(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .byte_if(if1), .tx(tx1), .busy(busy1)
    );
    uart_byte_tx #(.CLK_FREQ_HZ(4), .BAUD(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .byte_if(if2), .tx(tx2), .busy(busy2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic v, input logic [7:0] d);
        if (s == 1) begin
            if1.valid = v;
            if1.data  = d;
        end else begin
            if2.valid = v;
            if2.data  = d;
        end
    endtask

    function automatic logic get_tx(input int s);
        return (s == 1) ? tx1 : tx2;
    endfunction

    function automatic logic get_ready(input int s);
        return (s == 1) ? if1.ready : if2.ready;
    endfunction

    function automatic logic get_busy(input int s);
        return (s == 1) ? busy1 : busy2;
    endfunction

    // Line level c cycles after the handshake (c >= 1): start, 8 data LSB first, then stop.
    function automatic logic frame_bit(input logic [7:0] b, input int c);
        int k;
        k = (c - 1) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // Called in the handshake cycle T; returns in cycle T+1+frame length.
    // mode: 0 quiet, 1 random valid/data noise, 2 hold valid with next_b, 3 single 0xA5 pulse.
    task automatic run_frame(input int s, input logic [7:0] b, input int mode, input logic [7:0] next_b);
        int sb;
        int len;
        int lows;
        sb   = (s == 1) ? 1 : 2;
        len  = (9 + sb) * CPB;
        lows = 0;
        check_eq($sformatf("d%0d ready_at_handshake", s), get_ready(s), 1);
        drive(s, 1'b1, b);
        for (int c = 1; c <= len; c++) begin
            tick();
            case (mode)
                1: begin
                    if (c == len) drive(s, 1'b0, 8'h00);
                    else drive(s, 1'($urandom_range(0, 1)), 8'($urandom));
                end
                2: drive(s, 1'b1, next_b);
                3: drive(s, (c == 10), 8'hA5);
                default: drive(s, 1'b0, 8'h00);
            endcase
            check_eq($sformatf("d%0d b%02h tx c%0d", s, b, c), get_tx(s), frame_bit(b, c));
            check_eq($sformatf("d%0d b%02h ready c%0d", s, b, c), get_ready(s), 0);
            check_eq($sformatf("d%0d b%02h busy c%0d", s, b, c), get_busy(s), 1);
            if (get_tx(s) == 1'b0) lows++;
        end
        check_eq($sformatf("d%0d b%02h low_cycles", s, b), lows, CPB * (9 - $countones(b)));
        tick();
        check_eq($sformatf("d%0d b%02h ready_after", s, b), get_ready(s), 1);
        check_eq($sformatf("d%0d b%02h busy_after", s, b), get_busy(s), 0);
        check_eq($sformatf("d%0d b%02h tx_after", s, b), get_tx(s), 1);
    endtask

    // Start a frame, assert rst during cycle T+k, then expect an idle line.
    task automatic abort_frame(input int s, input logic [7:0] b, input int k);
        check_eq($sformatf("d%0d abort ready_at_handshake", s), get_ready(s), 1);
        drive(s, 1'b1, b);
        for (int c = 1; c <= k; c++) begin
            tick();
            drive(s, 1'b0, 8'h00);
            check_eq($sformatf("d%0d abort tx c%0d", s, c), get_tx(s), frame_bit(b, c));
            if (c == k) rst = 1'b1;
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 2 * int'(CPB); c++) begin
            check_eq($sformatf("d%0d abort idle tx %0d", s, c), get_tx(s), 1);
            check_eq($sformatf("d%0d abort idle ready %0d", s, c), get_ready(s), 1);
            check_eq($sformatf("d%0d abort idle busy %0d", s, c), get_busy(s), 0);
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        tick();
        tick();
        for (int s = 1; s <= 2; s++) begin
            check_eq($sformatf("d%0d reset tx", s), get_tx(s), 1);
            check_eq($sformatf("d%0d reset ready", s), get_ready(s), 1);
            check_eq($sformatf("d%0d reset busy", s), get_busy(s), 0);
        end
        rst = 1'b0;
        tick();

        run_frame(1, 8'h55, 0, 8'h00);
        run_frame(1, 8'h00, 2, 8'hFF);
        run_frame(1, 8'hFF, 0, 8'h00);
        run_frame(1, 8'h3C, 3, 8'h00);
        abort_frame(1, 8'h3C, 14);
        run_frame(1, 8'h81, 0, 8'h00);
        run_frame(2, 8'hF0, 0, 8'h00);

        // valid and rst in the same cycle: reset wins, no frame starts.
        rst = 1'b1;
        drive(1, 1'b1, 8'h00);
        drive(2, 1'b1, 8'h00);
        tick();
        rst = 1'b0;
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        for (int c = 0; c < 12; c++) begin
            for (int s = 1; s <= 2; s++) begin
                check_eq($sformatf("d%0d rst_valid tx %0d", s, c), get_tx(s), 1);
                check_eq($sformatf("d%0d rst_valid busy %0d", s, c), get_busy(s), 0);
            end
            tick();
        end

        for (int it = 0; it < 24; it++) begin
            int s;
            int gap;
            logic [7:0] b;
            s   = int'($urandom_range(1, 2));
            b   = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                check_eq($sformatf("d%0d gap tx", s), get_tx(s), 1);
                tick();
            end
            if ((it % 6) == 5) begin
                abort_frame(s, b, int'($urandom_range(1, (9 + s) * CPB - 1)));
            end else begin
                run_frame(s, b, int'($urandom_range(0, 1)), 8'h00);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
